// File: rtl/hamm_scrub_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | hamm_scrub_ctrl: walks a SEC-DED protected bank, fixes single-bit errors   |
// | in place and counts/flags uncorrectable words.                             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hamm_scrub_ctrl #(
  parameter int p_dataSize          = 32,
  parameter int p_checkSize         = 7,
  parameter int p_depth             = 8,
  parameter bit p_zeroWordDetection = 1'b1
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic                              start,
  input  logic                              hold,
  input  logic                              clr_counts,
  output logic                              rd_en,
  output logic [$clog2(p_depth)-1:0]        addr,
  input  logic [p_dataSize+p_checkSize-1:0] rd_codeword,
  output logic                              wr_en,
  output logic [p_dataSize+p_checkSize-1:0] wr_codeword,
  output logic                              busy,
  output logic                              done,
  output logic [7:0]                        ce_count,
  output logic [7:0]                        ue_count,
  output logic                              ue_flag,
  output logic [$clog2(p_depth)-1:0]        ue_addr
);

  localparam int HAM_BITS = p_checkSize - 1;
  localparam int HAM_POS  = p_dataSize + HAM_BITS;
  localparam int CW_BITS  = p_dataSize + p_checkSize;
  localparam int AW       = $clog2(p_depth);
  localparam logic [AW-1:0] LAST_ADDR = AW'(p_depth - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Data bits occupy the non-power-of-two Hamming positions, LSB first.
  function automatic logic [HAM_BITS-1:0] calc_check(input logic [p_dataSize-1:0] d);
    logic [HAM_BITS-1:0] c;
    int di;
    c  = '0;
    di = 0;
    for (int p = 1; p <= HAM_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < HAM_BITS; i++) begin
          if (p[i]) c[i] = c[i] ^ d[di];
        end
        di++;
      end
    end
    return c;
  endfunction

  function automatic logic [p_dataSize-1:0] fix_data(input logic [p_dataSize-1:0] d,
                                                     input logic [HAM_BITS-1:0]   syn);
    logic [p_dataSize-1:0] r;
    int di;
    r  = d;
    di = 0;
    for (int p = 1; p <= HAM_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (int'(syn) == p) r[di] = ~r[di];
        di++;
      end
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [CW_BITS-1:0]    wr_codeword_q, wr_codeword_d;
  logic [7:0]            ce_count_q, ce_count_d;
  logic [7:0]            ue_count_q, ue_count_d;
  logic                  ue_flag_q, ue_flag_d;
  logic [AW-1:0]         ue_addr_q, ue_addr_d;

  logic [p_dataSize-1:0] rx_data;
  logic [HAM_BITS-1:0]   syndrome;
  logic                  parity_bad;
  logic                  zero_word;
  logic                  is_ue;
  logic                  is_ce;
  logic [p_dataSize-1:0] fixed_data;
  logic [HAM_BITS-1:0]   fixed_check;
  logic                  ce_inc;
  logic                  ue_inc;

  assign rx_data     = rd_codeword[p_dataSize-1:0];
  assign syndrome    = calc_check(rx_data) ^ rd_codeword[p_dataSize +: HAM_BITS];
  assign parity_bad  = ^rd_codeword;
  assign zero_word   = p_zeroWordDetection && (rd_codeword == '0);
  // A bad overall parity means one flipped bit, wherever it landed.
  assign is_ue       = zero_word || (!parity_bad && (syndrome != '0));
  assign is_ce       = !zero_word && parity_bad;
  assign fixed_data  = fix_data(rx_data, syndrome);
  assign fixed_check = calc_check(fixed_data);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_codeword_d = wr_codeword_q;
    ce_count_d    = ce_count_q;
    ue_count_d    = ue_count_q;
    ue_flag_d     = ue_flag_q;
    ue_addr_d     = ue_addr_q;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    done          = 1'b0;
    ce_inc        = 1'b0;
    ue_inc        = 1'b0;
    busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start && !hold) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        if (!hold) begin
          rd_en   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (is_ue) begin
          ue_inc  = 1'b1;
          state_d = ST_NEXT;
        end else if (is_ce) begin
          ce_inc        = 1'b1;
          wr_codeword_d = {^{fixed_check, fixed_data}, fixed_check, fixed_data};
          state_d       = ST_WRITE;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear wins over any event recorded in the same cycle.
    if (clr_counts) begin
      ce_count_d = '0;
      ue_count_d = '0;
      ue_flag_d  = 1'b0;
      ue_addr_d  = '0;
    end else begin
      if (ce_inc && (ce_count_q != 8'hFF)) ce_count_d = ce_count_q + 8'd1;
      if (ue_inc && (ue_count_q != 8'hFF)) ue_count_d = ue_count_q + 8'd1;
      if (ue_inc) begin
        ue_flag_d = 1'b1;
        if (!ue_flag_q) ue_addr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wr_codeword_q <= '0;
      ce_count_q    <= '0;
      ue_count_q    <= '0;
      ue_flag_q     <= 1'b0;
      ue_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_codeword_q <= wr_codeword_d;
      ce_count_q    <= ce_count_d;
      ue_count_q    <= ue_count_d;
      ue_flag_q     <= ue_flag_d;
      ue_addr_q     <= ue_addr_d;
    end
  end

  assign addr        = addr_q;
  assign wr_codeword = wr_codeword_q;
  assign ce_count    = ce_count_q;
  assign ue_count    = ue_count_q;
  assign ue_flag     = ue_flag_q;
  assign ue_addr     = ue_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_hamm_scrub_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_hamm_scrub_ctrl: scoreboard bench for hamm_scrub_ctrl (default params). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_hamm_scrub_ctrl;

  localparam int DW    = 32;
  localparam int CW    = 39;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          clr_counts = 1'b0;
  logic          rd_en, wr_en, busy, done, ue_flag;
  logic [AW-1:0] addr, ue_addr;
  logic [CW-1:0] rd_codeword = '0;
  logic [CW-1:0] wr_codeword;
  logic [7:0]    ce_count, ue_count;

  always #5 clk = ~clk;

  hamm_scrub_ctrl dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .hold        (hold),
    .clr_counts  (clr_counts),
    .rd_en       (rd_en),
    .addr        (addr),
    .rd_codeword (rd_codeword),
    .wr_en       (wr_en),
    .wr_codeword (wr_codeword),
    .busy        (busy),
    .done        (done),
    .ce_count    (ce_count),
    .ue_count    (ue_count),
    .ue_flag     (ue_flag),
    .ue_addr     (ue_addr)
  );

  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] exp_cw [DEPTH];
  int            cls [DEPTH];   // 0 clean, 1 correctable, 2 uncorrectable
  bit            wb_en = 1'b1;
  int            cyc = 0;
  int            start_cyc = 0;
  int            n_reads = 0;
  int            checks = 0;
  int            errors = 0;

  typedef struct { int rel; logic [AW-1:0] a; } rd_t;
  typedef struct { int rel; logic [AW-1:0] a; logic [CW-1:0] cw; } wr_t;
  typedef struct { int rel; logic [7:0] ce; logic [7:0] ue; logic flag; logic [AW-1:0] ua; } dn_t;
  rd_t rdq[$];
  wr_t wrq[$];
  dn_t dnq[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_codeword <= mem[addr];

  // Independent encoder: each check bit is the XOR of the positions of set data bits.
  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [5:0] s;
    int k;
    s = '0;
    k = 0;
    for (int pos = 3; pos <= 38; pos++) begin
      if (pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
        if (d[k]) s = s ^ 6'(pos);
        k++;
      end
    end
    return {^{s, d}, s, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ue_flag"}, ue_flag, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_ue_addr"}, ue_addr, 0);
    chk({tag, "_ce_count"}, ce_count, 0);
    chk({tag, "_ue_count"}, ue_count, 0);
    chk({tag, "_wr_codeword"}, wr_codeword, 0);
  endtask

  task automatic fill_clean();
    for (int k = 0; k < DEPTH; k++) begin
      mem[k]    = enc(DW'(32'h0101_0101 * (k + 1)));
      exp_cw[k] = mem[k];
      cls[k]    = 0;
    end
  endtask

  task automatic clear_counts();
    @(negedge clk); clr_counts = 1'b1;
    @(negedge clk); clr_counts = 1'b0;
    chk("clr_ce", ce_count, 0);
    chk("clr_ue_flag", ue_flag, 0);
  endtask

  // Word timing: READ, CHECK, [WRITE,] NEXT, so 3 or 4 cycles per word.
  task automatic launch(input int n_words, input int stall_word, input int stall_len,
                        input bit push_done, input logic [7:0] e_ce, input logic [7:0] e_ue,
                        input logic e_flag, input logic [AW-1:0] e_ua);
    int t;
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    n_reads   = 0;
    t = 1;
    for (int k = 0; k < n_words; k++) begin
      if (k == stall_word) t += stall_len;
      rdq.push_back('{t, AW'(k)});
      if (cls[k] == 1) begin
        wrq.push_back('{t + 2, AW'(k), exp_cw[k]});
        t += 4;
      end else begin
        t += 3;
      end
    end
    if (push_done) dnq.push_back('{t, e_ce, e_ue, e_flag, e_ua});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - start_cyc < r) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && dnq.size() != 0; i++) @(negedge clk);
    chk("done_timeout", dnq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int  rel;
    rd_t r;
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      #1;
      if (rstN) begin
        rel = cyc - start_cyc;
        if (rd_en) begin
          n_reads++;
          if (rdq.size() == 0) chk("unexpected_rd", rd_en, 0);
          else begin
            r = rdq.pop_front();
            chk("rd_cycle", rel, r.rel);
            chk("rd_addr", addr, r.a);
          end
        end
        if (wr_en) begin
          if (wb_en) mem[addr] = wr_codeword;
          if (wrq.size() == 0) chk("unexpected_wr", wr_en, 0);
          else begin
            w = wrq.pop_front();
            chk("wr_cycle", rel, w.rel);
            chk("wr_addr", addr, w.a);
            chk("wr_codeword", wr_codeword, w.cw);
          end
        end
        if (done) begin
          if (dnq.size() == 0) chk("unexpected_done", done, 0);
          else begin
            d = dnq.pop_front();
            chk("done_cycle", rel, d.rel);
            chk("done_busy", busy, 0);
            chk("done_addr", addr, 0);
            chk("done_ce", ce_count, d.ce);
            chk("done_ue", ue_count, d.ue);
            chk("done_ue_flag", ue_flag, d.flag);
            chk("done_ue_addr", ue_addr, d.ua);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] bad4;
    fill_clean();
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstN = 1'b1;
    @(negedge clk);

    // Clean bank; a second start mid-pass must not disturb the schedule.
    launch(8, -1, 0, 1, 8'd0, 8'd0, 1'b0, '0);
    wait_rel(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("clean_reads", n_reads, 8);

    // Single data-bit error in word 3.
    fill_clean();
    clear_counts();
    mem[3]    = 39'h72_A5A5_A5A5 ^ (39'h1 << 7);
    exp_cw[3] = 39'h72_A5A5_A5A5;
    cls[3]    = 1;
    launch(8, -1, 0, 1, 8'd1, 8'd0, 1'b0, '0);
    wait_done();
    chk("ce_writeback", mem[3], 39'h72_A5A5_A5A5);

    // Double-bit errors in words 5 and 6.
    fill_clean();
    clear_counts();
    mem[5] = mem[5] ^ (39'h1 << 0) ^ (39'h1 << 9);
    mem[6] = mem[6] ^ (39'h1 << 12) ^ (39'h1 << 31);
    cls[5] = 2;
    cls[6] = 2;
    launch(8, -1, 0, 1, 8'd0, 8'd2, 1'b1, AW'(5));
    wait_done();

    // All-zero codeword at word 0.
    fill_clean();
    clear_counts();
    mem[0] = '0;
    cls[0] = 2;
    launch(8, -1, 0, 1, 8'd0, 8'd1, 1'b1, AW'(0));
    wait_done();

    // Every word single-bit bad, no write-back: saturation, then clear on an increment.
    fill_clean();
    wb_en = 1'b0;
    for (int k = 0; k < 6; k++) mem[k] = mem[k] ^ (39'h1 << (4 * k + 1));
    mem[6] = mem[6] ^ (39'h1 << 33);
    mem[7] = mem[7] ^ (39'h1 << 38);
    for (int k = 0; k < DEPTH; k++) cls[k] = 1;
    clear_counts();
    for (int p = 0; p < 40; p++) begin
      launch(8, -1, 0, 1, ((p + 1) * 8 > 255) ? 8'd255 : 8'((p + 1) * 8), 8'd0, 1'b0, '0);
      wait_done();
    end
    launch(8, -1, 0, 1, 8'd7, 8'd0, 1'b0, '0);
    wait_rel(2);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    chk("clr_in_inc_cycle", ce_count, 0);
    wait_done();

    // Hold stall on word 2, reset during the write of word 4.
    fill_clean();
    wb_en  = 1'b1;
    mem[4] = mem[4] ^ (39'h1 << 20);
    bad4   = mem[4];
    cls[4] = 1;
    clear_counts();
    launch(5, 2, 5, 0, 8'd0, 8'd0, 1'b0, '0);
    wait_rel(6);
    @(posedge clk); #1 hold = 1'b1;
    repeat (5) @(posedge clk);
    #1 hold = 1'b0;
    wait_rel(19);
    @(posedge clk); #1 rstN = 1'b0;
    #1;
    check_zero("abort");
    chk("abort_reads", n_reads, 5);
    chk("abort_rdq", rdq.size(), 0);
    chk("abort_write_not_seen", wrq.size(), 1);
    chk("abort_mem4", mem[4], bad4);
    wrq.delete();
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_abort_busy", busy, 0);

    chk("end_rdq", rdq.size(), 0);
    chk("end_wrq", wrq.size(), 0);
    chk("end_dnq", dnq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
